// File: rtl/chess_turn_scheduler.sv
// Two-player chess clock turn controller: button arbitration, per-player
// remaining-time registers, Fischer increment and sticky time-out flag.
module chess_turn_scheduler #(
  parameter int unsigned TIME_W     = 10,
  parameter int unsigned START_TIME = 300,
  parameter int unsigned INCREMENT  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic [1:0]        i_btn,
  input  logic              i_pause,
  output logic [TIME_W-1:0] o_time1,
  output logic [TIME_W-1:0] o_time2,
  output logic [1:0]        o_active,
  output logic [1:0]        o_flag,
  output logic [2:0]        o_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN1  = 3'd1;
  localparam logic [2:0] S_RUN2  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_FLAG  = 3'd4;

  localparam logic [TIME_W:0]   TIME_MAX  = {1'b0, {TIME_W{1'b1}}};
  localparam logic [TIME_W:0]   INC_EXT   = (TIME_W+1)'(INCREMENT);
  localparam logic [TIME_W-1:0] START_VAL = TIME_W'(START_TIME);
  localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);

  logic [1:0]        sync1, sync2, prev;
  logic [1:0]        rise;
  logic              paused_p2;

  logic [2:0]        state_n;
  logic [TIME_W-1:0] time1_n, time2_n;
  logic [1:0]        flag_n, active_n;
  logic              paused_n;
  logic [TIME_W-1:0] dec1, dec2;

  // Adds the increment to a time value, clamping at the register maximum.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] t);
    logic [TIME_W:0] s;
    s = {1'b0, t} + INC_EXT;
    return (s > TIME_MAX) ? TIME_MAX[TIME_W-1:0] : s[TIME_W-1:0];
  endfunction

  assign rise = sync2 & ~prev;
  assign dec1 = o_time1 - TIME_W'(i_tick);
  assign dec2 = o_time2 - TIME_W'(i_tick);

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      prev  <= 2'b00;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State, time, flag and active registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_state   <= S_IDLE;
      o_time1   <= START_VAL;
      o_time2   <= START_VAL;
      o_flag    <= 2'b00;
      o_active  <= 2'b00;
      paused_p2 <= 1'b0;
    end else begin
      o_state   <= state_n;
      o_time1   <= time1_n;
      o_time2   <= time2_n;
      o_flag    <= flag_n;
      o_active  <= active_n;
      paused_p2 <= paused_n;
    end
  end

  // Next-state logic: pause beats time-out, time-out beats a turn switch.
  always_comb begin
    state_n  = o_state;
    time1_n  = o_time1;
    time2_n  = o_time2;
    flag_n   = o_flag;
    paused_n = paused_p2;
    case (o_state)
      S_IDLE: begin
        if (rise == 2'b01)      state_n = S_RUN2;
        else if (rise == 2'b10) state_n = S_RUN1;
      end
      S_RUN1: begin
        if (i_pause) begin
          state_n  = S_PAUSE;
          paused_n = 1'b0;
        end else if (i_tick && (o_time1 == ONE)) begin
          time1_n = '0;
          flag_n  = 2'b01;
          state_n = S_FLAG;
        end else begin
          time1_n = dec1;
          if (rise[0]) begin
            time1_n = sat_inc(dec1);
            state_n = S_RUN2;
          end
        end
      end
      S_RUN2: begin
        if (i_pause) begin
          state_n  = S_PAUSE;
          paused_n = 1'b1;
        end else if (i_tick && (o_time2 == ONE)) begin
          time2_n = '0;
          flag_n  = 2'b10;
          state_n = S_FLAG;
        end else begin
          time2_n = dec2;
          if (rise[1]) begin
            time2_n = sat_inc(dec2);
            state_n = S_RUN1;
          end
        end
      end
      S_PAUSE: begin
        if (!i_pause) state_n = paused_p2 ? S_RUN2 : S_RUN1;
      end
      S_FLAG: begin
        state_n = S_FLAG;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    active_n = (state_n == S_RUN1) ? 2'b01 :
               (state_n == S_RUN2) ? 2'b10 : 2'b00;
  end

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Bench for chess_turn_scheduler: three instances with different start times
// share one stimulus stream and are checked every cycle against a
// turn-level model, plus hand-computed checkpoints.
module tb_chess_turn_scheduler;

  localparam int unsigned TW = 10;
  localparam int NI = 3;
  localparam int TMAX = 1023;

  logic clk = 1'b0;
  logic i_reset;
  logic tick;
  logic [1:0] btn;
  logic pause;

  logic [TW-1:0] t1 [NI];
  logic [TW-1:0] t2 [NI];
  logic [1:0]    act [NI];
  logic [1:0]    flg [NI];
  logic [2:0]    st [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chess_turn_scheduler #(.TIME_W(TW), .START_TIME(300), .INCREMENT(2)) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_tick(tick), .i_btn(btn), .i_pause(pause),
    .o_time1(t1[0]), .o_time2(t2[0]), .o_active(act[0]), .o_flag(flg[0]), .o_state(st[0]));
  chess_turn_scheduler #(.TIME_W(TW), .START_TIME(2), .INCREMENT(2)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_tick(tick), .i_btn(btn), .i_pause(pause),
    .o_time1(t1[1]), .o_time2(t2[1]), .o_active(act[1]), .o_flag(flg[1]), .o_state(st[1]));
  chess_turn_scheduler #(.TIME_W(TW), .START_TIME(1023), .INCREMENT(2)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_tick(tick), .i_btn(btn), .i_pause(pause),
    .o_time1(t1[2]), .o_time2(t2[2]), .o_active(act[2]), .o_flag(flg[2]), .o_state(st[2]));

  // Model: remaining time per player, who is running (0 none, 1, 2),
  // whether the game is paused and who (if anyone) timed out.
  int m_t [NI][2];
  int m_run [NI];
  bit m_paused [NI];
  int m_flag [NI];
  bit [1:0] h0, h1, h2;   // button samples from 1, 2 and 3 edges ago

  function automatic int start_of(input int i);
    return (i == 0) ? 300 : (i == 1) ? 2 : 1023;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_t[i][0] = start_of(i);
      m_t[i][1] = start_of(i);
      m_run[i] = 0;
      m_paused[i] = 1'b0;
      m_flag[i] = 0;
    end
    h0 = 2'b00; h1 = 2'b00; h2 = 2'b00;
  endtask

  task automatic model_step(input int i, input bit tk, input bit [1:0] r, input bit pz);
    int p;
    if (m_flag[i] != 0) return;
    if (m_paused[i]) begin
      if (!pz) m_paused[i] = 1'b0;
      return;
    end
    if (m_run[i] == 0) begin
      if (r == 2'b01) m_run[i] = 2;
      else if (r == 2'b10) m_run[i] = 1;
      return;
    end
    p = m_run[i];
    if (pz) begin
      m_paused[i] = 1'b1;
      return;
    end
    if (tk && m_t[i][p-1] == 1) begin
      m_t[i][p-1] = 0;
      m_flag[i] = p;
      m_run[i] = 0;
      return;
    end
    if (tk) m_t[i][p-1] = m_t[i][p-1] - 1;
    if (r[p-1]) begin
      m_t[i][p-1] = (m_t[i][p-1] + 2 > TMAX) ? TMAX : m_t[i][p-1] + 2;
      m_run[i] = 3 - p;
    end
  endtask

  // Model update: a button press is seen two edges after it is sampled.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      model_reset();
    end else begin
      bit [1:0] r;
      r = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = btn;
      for (int i = 0; i < NI; i++) model_step(i, tick, r, pause);
    end
  end

  function automatic int exp_state(input int i);
    if (m_flag[i] != 0) return 4;
    if (m_run[i] == 0) return 0;
    if (m_paused[i]) return 3;
    return m_run[i];
  endfunction

  function automatic int exp_active(input int i);
    if (m_flag[i] != 0 || m_run[i] == 0 || m_paused[i]) return 0;
    return 1 << (m_run[i] - 1);
  endfunction

  function automatic int exp_flag(input int i);
    return (m_flag[i] == 0) ? 0 : (1 << (m_flag[i] - 1));
  endfunction

  task automatic chk(input string nm, input int i, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, i, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("time1", i, int'(t1[i]), m_t[i][0]);
      chk("time2", i, int'(t2[i]), m_t[i][1]);
      chk("state", i, int'(st[i]), exp_state(i));
      chk("active", i, int'(act[i]), exp_active(i));
      chk("flag", i, int'(flg[i]), exp_flag(i));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_btn(input logic [1:0] b);
    btn = b;
    @(negedge clk);
    btn = 2'b00;
    cyc(4);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc(2);
    i_reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    i_reset = 1'b0; tick = 1'b0; btn = 2'b00; pause = 1'b0;
    #1 i_reset = 1'b1;
    cyc(3);
    chk("lit_rst_state", 0, int'(st[0]), 0);
    chk("lit_rst_time1", 0, int'(t1[0]), 300);
    i_reset = 1'b0;
    @(negedge clk);

    // P2 presses: P1 clock runs for three seconds
    pulse_btn(2'b10);
    repeat (3) do_tick();
    chk("lit_run1_state", 0, int'(st[0]), 1);
    chk("lit_run1_active", 0, int'(act[0]), 1);
    chk("lit_run1_time1", 0, int'(t1[0]), 297);
    chk("lit_run1_time2", 0, int'(t2[0]), 300);
    chk("lit_timeout_state", 1, int'(st[1]), 4);
    chk("lit_timeout_flag", 1, int'(flg[1]), 1);
    chk("lit_timeout_time1", 1, int'(t1[1]), 0);

    // P1 ends turn: increment, P2 runs; flagged instance ignores it
    pulse_btn(2'b01);
    chk("lit_sw_state", 0, int'(st[0]), 2);
    chk("lit_sw_time1", 0, int'(t1[0]), 299);
    chk("lit_flag_hold", 1, int'(st[1]), 4);
    do_tick();
    chk("lit_run2_time2", 0, int'(t2[0]), 299);
    pulse_btn(2'b01);
    chk("lit_wrong_btn", 0, int'(st[0]), 2);

    // pause freezes P2
    pause = 1'b1;
    cyc(2);
    repeat (5) do_tick();
    chk("lit_pause_time2", 0, int'(t2[0]), 299);
    chk("lit_pause_state", 0, int'(st[0]), 3);
    chk("lit_pause_active", 0, int'(act[0]), 0);
    pause = 1'b0;
    cyc(2);
    chk("lit_resume_state", 0, int'(st[0]), 2);
    do_tick();
    chk("lit_resume_time2", 0, int'(t2[0]), 298);

    // asynchronous reset mid-cycle
    i_reset = 1'b1;
    #1;
    chk("lit_async_state", 0, int'(st[0]), 0);
    chk("lit_async_time2", 0, int'(t2[0]), 300);
    chk("lit_async_active", 0, int'(act[0]), 0);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);

    // simultaneous presses in IDLE, then a long hold
    pulse_btn(2'b11);
    chk("lit_both_state", 0, int'(st[0]), 0);
    chk("lit_both_time1", 0, int'(t1[0]), 300);
    btn = 2'b01;
    cyc(1000);
    btn = 2'b00;
    cyc(2);
    chk("lit_hold_state", 0, int'(st[0]), 2);

    // saturation of the increment
    do_reset();
    pulse_btn(2'b10);
    pulse_btn(2'b01);
    chk("lit_sat_time1", 2, int'(t1[2]), 1023);
    chk("lit_sat_state", 2, int'(st[2]), 2);
    chk("lit_inc_time1", 0, int'(t1[0]), 302);

    // tick and turn end in the same cycle at one second left
    do_reset();
    pulse_btn(2'b10);
    do_tick();
    btn = 2'b01;
    @(negedge clk);
    btn = 2'b00;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(2);
    chk("lit_race_state", 1, int'(st[1]), 4);
    chk("lit_race_time1", 1, int'(t1[1]), 0);
    chk("lit_race_flag", 1, int'(flg[1]), 1);
    chk("lit_race_other", 0, int'(t1[0]), 300);

    // randomized play
    for (int k = 0; k < 4000; k++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 4) == 0) btn = 2'($urandom_range(0, 3));
      i_reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    i_reset = 1'b0; tick = 1'b0; btn = 2'b00; pause = 1'b0;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chess_turn_scheduler.md
Name: chess_turn_scheduler

Overview:
Turn controller for the two-player chess timer. It arbitrates the two player push-buttons and decides which player's clock runs. It owns both players' remaining-time registers, decrements the active one on each 1 s strobe, applies a Fischer increment when a turn ends, and raises a flag at time-out. It sits between the 1 s strobe generator and the display controller, replacing discrete load/enable wiring to per-player counters.

Parameters:
TIME_W, 10, width of each time register (seconds)
START_TIME, 300, value loaded into both time registers on reset
INCREMENT, 2, seconds added to a player's time when that player ends a turn

Ports:
i_clk  input  1  system clock (50 MHz)
i_reset  input  1  asynchronous, active-high reset
i_tick  input  1  one-i_clk-cycle strobe, once per second, synchronous to i_clk
i_btn  input  2  raw player buttons, active-high level, asynchronous; bit0 = player 1, bit1 = player 2
i_pause  input  1  level; high freezes the running clock
o_time1  output  TIME_W  player 1 remaining seconds
o_time2  output  TIME_W  player 2 remaining seconds
o_active  output  2  one-hot running player (01 = P1, 10 = P2, 00 = none)
o_flag  output  2  one-hot player who ran out of time; sticky
o_state  output  3  FSM state code, for LEDs and debug

Behaviour:
- Reset (async, active-high): o_time1 = o_time2 = START_TIME, state IDLE, o_active = 00, o_flag = 00, synchronizer flops = 0. All outputs are registered.
- Button path: each bit passes through a 2-flop synchronizer, then a previous-value register. A rise is sync2 & ~prev. The FSM acts on a rise on the 3rd rising i_clk edge after the input is first sampled high. A held button produces exactly one rise.
- State codes: IDLE = 0, RUN1 = 1, RUN2 = 2, PAUSE = 3, FLAG = 4.
- IDLE: no clock runs and ticks are ignored.
  - Rise on btn[0] only -> RUN2. Rise on btn[1] only -> RUN1. The presser starts the opponent's clock.
  - Simultaneous rises -> stay in IDLE.
  - i_pause is ignored.
- RUN1: o_active = 01.
  - i_tick -> o_time1 - 1.
  - Rise on btn[0] -> RUN2, and o_time1 += INCREMENT, saturating at 2^TIME_W - 1. Rise on btn[1] is ignored.
  - Tick and btn[0] rise in the same cycle: o_time1 = o_time1 - 1 + INCREMENT, saturated, then -> RUN2.
  - If the tick makes o_time1 reach 0, FLAG wins: o_time1 = 0, no increment, no switch, o_flag = 01.
- RUN2: mirror of RUN1 with the players swapped. Flag value is o_flag = 10.
- PAUSE: entered from RUN1 or RUN2 when i_pause = 1. Pause takes priority over a tick or button in the same cycle.
  - A 1-bit register remembers the paused player. o_active = 00.
  - Ticks and button rises are ignored.
  - i_pause = 0 -> return to the remembered RUN state on the next clock.
- FLAG: terminal state. Times are frozen, o_active = 00, o_flag is held. Only i_reset leaves it.
- Decrement never underflows, because reaching 0 always forces FLAG.
- START_TIME = 0 is illegal; behaviour is undefined.
- Reset asserted mid-game returns everything to reset values immediately, with no clock required.

Test Plan:
- Reset, then btn[1] pulse; wait 3 ticks -> o_state = 1, o_active = 01, o_time1 = 297, o_time2 = 300.
- In RUN1 with o_time1 = 297, pulse btn[0] -> o_state = 2, o_time1 = 299, then 1 tick -> o_time2 = 299. A btn[0] pulse in RUN2 has no effect.
- Both buttons rise in the same cycle in IDLE -> state stays 0, times unchanged. A btn held for 1000 cycles from IDLE causes exactly one transition.
- In RUN2, assert i_pause and apply 5 ticks -> o_time2 unchanged, o_state = 3, o_active = 00. Release i_pause -> o_state = 2 and decrementing resumes.
- START_TIME = 2: start RUN1, apply 2 ticks -> o_time1 = 0, o_state = 4, o_flag = 01. Further buttons and ticks change nothing. i_reset -> both times 2, o_flag = 00.
- In RUN1 at o_time1 = 1, apply tick and btn[0] rise in the same cycle -> FLAG, o_time1 = 0, no increment. In a separate run, o_time1 = 1023 with btn[0] -> o_time1 saturates at 1023.
